des_output_serializer: RTL and testbench



---
 rtl/des_pkg.sv | 34 +++
 rtl/des_block_fifo.sv | 89 ++++++++
 rtl/des_output_serializer.sv | 83 ++++++++
 tb/tb_des_output_serializer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared widths, types and the byte-select helper for the
//                DES output serializer slice.
//  Revision    : 1.0  initial release
// ============================================================================
package des_pkg;

    localparam int BLOCK_W         = 64;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 8;
    localparam int BYTE_IDX_W      = $clog2(BYTES_PER_BLOCK);

    typedef logic [BLOCK_W-1:0]    block_t;
    typedef logic [BYTE_W-1:0]     byte_t;
    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_BLOCK - 1);

    // Byte 0 is the most significant byte of the block (DES bit 1 = MSB).
    function automatic byte_t select_byte(input block_t blk, input byte_idx_t idx);
        byte_t r;
        r = '0;
        for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
            if (idx == byte_idx_t'(k)) begin
                r = blk[BLOCK_W-1-BYTE_W*k -: BYTE_W];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_block_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : des_block_fifo
//  Description : Circular FIFO of DEPTH 64-bit ciphertext blocks with
//                occupancy count and full/empty flags.
//  Revision    : 1.0  initial release
// ============================================================================
module des_block_fifo
    import des_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  block_t                 push_data,
    input  logic                   pop,
    output block_t                 pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    block_t             mem_q [DEPTH];
    block_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Guard against overflow/underflow so the count can never run away.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop  && !empty;

    // Storage write: only the slot at the write pointer changes.
    always_comb begin
        mem_d = mem_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Block storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/des_output_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : des_output_serializer
//  Description : Buffers 64-bit ciphertext blocks and streams each one as
//                8 bytes, most significant byte first, over valid/ready.
//                External bit 1 of in/out maps to the MSB of each vector.
//  Revision    : 1.0  initial release
// ============================================================================
module des_output_serializer
    import des_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BYTE_W-1:0]  out,
    output logic               out_last,
    output logic               busy
);

    byte_idx_t              byte_idx_q, byte_idx_d;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_byte_fire;
    block_t                 w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;

    // in_ready comes from registered occupancy only, so there is no
    // combinational path from out_ready back to the upstream.
    assign in_ready    = !w_full;
    assign w_push      = in_valid && in_ready;
    assign out_valid   = (w_count != '0);
    assign w_byte_fire = out_valid && out_ready;
    assign w_pop       = w_byte_fire && (byte_idx_q == LAST_BYTE_IDX);

    des_block_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Advance to the next byte on each accepted byte; wrap after the last.
    always_comb begin
        byte_idx_d = byte_idx_q;
        if (w_byte_fire) begin
            if (byte_idx_q == LAST_BYTE_IDX) begin
                byte_idx_d = '0;
            end else begin
                byte_idx_d = byte_idx_q + byte_idx_t'(1);
            end
        end
    end

    // Byte position within the head block; reset drops any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
        end
    end

    assign out      = select_byte(w_head, byte_idx_q);
    assign out_last = out_valid && (byte_idx_q == LAST_BYTE_IDX);
    assign busy     = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_des_output_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_output_serializer
//  Description : Scoreboard bench for des_output_serializer (DEPTH = 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_des_output_serializer;

    localparam int DEPTH = 2;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [63:0] din       = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  dout;
    logic        out_last;
    logic        busy;

    typedef struct {
        logic [7:0] b;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    des_output_serializer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected bytes are queued when a block is accepted and
    // compared/popped as the DUT presents and hands off bytes.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", 64'd1, 64'd0);
                end else begin
                    check("out_byte", {56'd0, dout}, {56'd0, sb[0].b});
                    check("out_last", {63'd0, out_last}, {63'd0, sb[0].l});
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                check("last_idle", {63'd0, out_last}, 64'd0);
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < 8; k++) begin
                    sb.push_back('{b: din[63-8*k -: 8], l: (k == 7)});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int maxc, output int cycles);
        cycles = 0;
        while (sb.size() != 0 && cycles < maxc) begin
            tick();
            cycles++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic push_one(input logic [63:0] blk);
        int guard = 0;
        in_valid = 1'b1;
        din      = blk;
        while (!in_ready && guard < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check("push_timeout", 64'(guard < 100), 64'd1);
        out_ready = 1'($urandom_range(0, 1));
        tick();
        in_valid = 1'b0;
        din      = {$urandom, $urandom};
    endtask

    initial begin
        int           c;
        int           guard;
        logic         stalled;
        logic [7:0]   prev;
        logic [63:0]  blk;
        logic [3:0]   pat;

        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);

        // Single block, consumer always ready.
        blk       = 64'h85E813540F0AB405;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = blk;
        tick();
        in_valid  = 1'b0;
        din       = {$urandom, $urandom};
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_byte0", 64'(dout), 64'h85);
        drain("t1_drain", 20, c);
        check("t1_cycles", 64'(c), 64'd8);
        check("t1_busy", 64'(busy), 64'd0);

        // Same block with back-pressure pattern 1,0,0,1,...
        pat      = 4'b1001;
        in_valid = 1'b1;
        din      = blk;
        tick();
        in_valid = 1'b0;
        guard    = 0;
        stalled  = 1'b0;
        prev     = '0;
        while (sb.size() != 0 && guard < 64) begin
            if (stalled) check("stall_hold", 64'(dout), 64'(prev));
            out_ready = pat[3 - (guard % 4)];
            stalled   = out_valid && !out_ready;
            prev      = dout;
            tick();
            guard++;
        end
        check("t2_drain", 64'(sb.size()), 64'd0);
        check("t2_busy", 64'(busy), 64'd0);

        // Fill to DEPTH with consumer stalled, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din       = 64'h0123456789ABCDEF;
        tick();
        check("fill1_in_ready", 64'(in_ready), 64'd1);
        din = 64'hFEDCBA9876543210;
        tick();
        check("full_in_ready", 64'(in_ready), 64'd0);
        din = 64'h1122334455667788;
        tick();
        check("held_in_ready", 64'(in_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("stream_valid", 64'(out_valid), 64'd1);
            tick();
        end
        check("a_last", 64'(out_last), 64'd1);
        check("a_last_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("reopen_in_ready", 64'(in_ready), 64'd1);
        tick();
        // Third block now accepted; present a fourth while full.
        check("refull_in_ready", 64'(in_ready), 64'd0);
        din   = 64'hA5A5_5A5A_C3C3_3C3C;
        guard = 0;
        while (guard < 40) begin
            check("no_bubble", 64'(out_valid), 64'd1);
            if (in_ready) break;
            tick();
            guard++;
        end
        check("d_accept_timeout", 64'(guard < 40), 64'd1);
        tick();
        in_valid = 1'b0;
        drain("t3_drain", 64, c);
        check("t3_busy", 64'(busy), 64'd0);

        // Random stream with random back-pressure.
        for (int i = 0; i < 4; i++) push_one({$urandom, $urandom});
        out_ready = 1'b1;
        drain("t4_drain", 80, c);

        // Reset in the middle of a block.
        blk      = 64'h0F1E2D3C4B5A6978;
        in_valid = 1'b1;
        din      = blk;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        check("mid_rst_busy",      64'(busy),      64'd0);
        blk      = 64'hC0FFEE0012345678;
        in_valid = 1'b1;
        din      = blk;
        tick();
        in_valid = 1'b0;
        check("post_rst_byte0", 64'(dout), 64'hC0);
        drain("t5_drain", 20, c);
        check("t5_cycles", 64'(c), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
